// File: rtl/frame_aligner_lock_if.sv
// rtl/frame_aligner_lock_if.sv - S-bit/SoT data path and status bundle for frame_aligner_lock
interface frame_aligner_lock_if #(
   parameter int FRAME_SIZE = 8,
   parameter int NLANES     = 8,
   parameter int ERR_CNT_W  = 16
);
   localparam int MXSBITS = NLANES * FRAME_SIZE;
   localparam int SLIP_W  = $clog2(FRAME_SIZE);

   logic [MXSBITS-1:0]    sbits_i;
   logic [FRAME_SIZE-1:0] start_of_frame_i;
   logic                  mask_i;
   logic                  err_clr_i;
   logic [11:0]           aligned_count_to_ready_i;
   logic [MXSBITS-1:0]    sbits_o;
   logic [SLIP_W-1:0]     bitslip_o;
   logic                  sot_is_aligned_o;
   logic                  sot_unstable_o;
   logic [ERR_CNT_W-1:0]  sot_err_cnt_o;

   modport master (
      output sbits_i, start_of_frame_i, mask_i, err_clr_i, aligned_count_to_ready_i,
      input  sbits_o, bitslip_o, sot_is_aligned_o, sot_unstable_o, sot_err_cnt_o
   );

   modport slave (
      input  sbits_i, start_of_frame_i, mask_i, err_clr_i, aligned_count_to_ready_i,
      output sbits_o, bitslip_o, sot_is_aligned_o, sot_unstable_o, sot_err_cnt_o
   );
endinterface

// File: rtl/frame_aligner_lock.sv
// rtl/frame_aligner_lock.sv - SoT-driven bitslip realignment of one VFAT S-bit group with lock FSM
module frame_aligner_lock #(
   parameter int FRAME_SIZE  = 8,
   parameter int NLANES      = 8,
   parameter int MXSBITS     = NLANES * FRAME_SIZE,
   parameter int SOT_OFFSET  = 1,
   parameter int UNLOCK_ERRS = 4,
   parameter int ERR_CNT_W   = 16,
   parameter int SLIP_W      = $clog2(FRAME_SIZE)
) (
   input  logic                 clock,
   input  logic                 reset_n_i,
   frame_aligner_lock_if.slave  bus
);
   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam int         ERW       = $clog2(UNLOCK_ERRS + 2);

   logic [MXSBITS-1:0]    d1, d2, sbits_q, aligned_data;
   logic [FRAME_SIZE-1:0] sof_r;
   logic [SLIP_W-1:0]     slip, sof_idx, cand;
   logic [11:0]           stable_cnt;
   logic [ERW-1:0]        err_run, err_run_inc;
   logic [0:0]            state;
   logic                  aligned_q, unstable_q, sof_valid, good;
   logic [ERR_CNT_W-1:0]  err_cnt;
   logic [2*FRAME_SIZE-1:0] pair, shifted;

   always_comb begin
      sof_idx = '0;
      for (int i = 0; i < FRAME_SIZE; i++)
         if (sof_r[i]) sof_idx = SLIP_W'(i);
   end

   // Slip arithmetic wraps naturally because FRAME_SIZE is a power of two.
   assign sof_valid   = $onehot(sof_r);
   assign cand        = sof_idx + SLIP_W'(SOT_OFFSET % FRAME_SIZE);
   assign good        = sof_valid && (cand == slip);
   assign err_run_inc = err_run + ERW'(1);

   // Newer word (d1) supplies the bits that spill past the older word (d2).
   always_comb begin
      aligned_data = '0;
      pair         = '0;
      shifted      = '0;
      for (int l = 0; l < NLANES; l++) begin
         pair    = {d1[l*FRAME_SIZE +: FRAME_SIZE], d2[l*FRAME_SIZE +: FRAME_SIZE]};
         shifted = pair >> slip;
         aligned_data[l*FRAME_SIZE +: FRAME_SIZE] = shifted[FRAME_SIZE-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n_i) begin
      if (!reset_n_i) begin
         d1         <= '0;
         d2         <= '0;
         sof_r      <= '0;
         sbits_q    <= '0;
         slip       <= '0;
         stable_cnt <= '0;
         err_run    <= '0;
         state      <= ST_HUNT;
         aligned_q  <= 1'b0;
         unstable_q <= 1'b0;
         err_cnt    <= '0;
      end else begin
         d1        <= bus.sbits_i;
         d2        <= d1;
         sof_r     <= bus.start_of_frame_i;
         sbits_q   <= bus.mask_i ? '0 : aligned_data;
         aligned_q <= (state == ST_LOCKED);

         if (bus.mask_i) begin
            state      <= ST_HUNT;
            stable_cnt <= '0;
            err_run    <= '0;
         end else if (state == ST_HUNT) begin
            if (sof_valid && (cand != slip)) begin
               slip       <= cand;
               stable_cnt <= '0;
            end else if (good) begin
               // A threshold lowered below the running count restarts the count.
               if (stable_cnt == bus.aligned_count_to_ready_i)
                  state <= ST_LOCKED;
               else if (stable_cnt > bus.aligned_count_to_ready_i)
                  stable_cnt <= '0;
               else
                  stable_cnt <= stable_cnt + 12'd1;
            end else begin
               stable_cnt <= '0;
            end
         end else begin
            if (good) begin
               err_run <= '0;
            end else begin
               if (err_cnt != '1)
                  err_cnt <= err_cnt + ERR_CNT_W'(1);
               if ((UNLOCK_ERRS != 0) && (err_run_inc == ERW'(UNLOCK_ERRS))) begin
                  state      <= ST_HUNT;
                  stable_cnt <= '0;
                  err_run    <= '0;
                  unstable_q <= 1'b1;
               end else if (UNLOCK_ERRS != 0) begin
                  err_run <= err_run_inc;
               end
            end
         end

         if (bus.err_clr_i) begin
            err_cnt    <= '0;
            unstable_q <= 1'b0;
         end
      end
   end

   assign bus.sbits_o          = sbits_q;
   assign bus.bitslip_o        = slip;
   assign bus.sot_is_aligned_o = aligned_q;
   assign bus.sot_unstable_o   = unstable_q;
   assign bus.sot_err_cnt_o    = err_cnt;
endmodule
